score_display_n: RTL and testbench

- Parametrised successor of the 4-digit score display block.
- Converts a binary score to N BCD digits using its own sequential double-dabble engine with a start/busy/done handshake.
- Drives a multiplexed, active-low seven-segment display with N digit enables.
- Produces a pixel-aligned on-screen score overlay with position and integer scale set by parameters, using an external 1-cycle-latency glyph ROM.
- Sits between the eggs/score logic and the VGA pixel mixer.

---
 rtl/score_pkg.sv | 38 +++
 rtl/score_display_n_bin2bcd.sv | 127 ++++++++++++
 rtl/score_display_n.sv | 124 ++++++++++++
 tb/tb_score_display_n.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared constants, converter state encoding and helpers for score_display_n.
package score_pkg;

   localparam int unsigned GLYPH_W    = 16;
   localparam logic [3:0]  BLANK_CODE = 4'hF;

   // Active-low {dp, a, b, c, d, e, f, g}, indexed by decimal digit.
   localparam logic [7:0] SEG_PAT [10] = '{
      8'b10000001, 8'b11001111, 8'b10010010, 8'b10000110, 8'b11001100,
      8'b10100100, 8'b10100000, 8'b10001111, 8'b10000000, 8'b10000100
   };

   typedef enum logic [1:0] {
      CONV_IDLE,
      CONV_SHIFT,
      CONV_COMMIT
   } conv_state_e;

   function automatic logic [31:0] pow10(input int unsigned n);
      logic [31:0] p;
      p = 32'd1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 32'd10;
      end
      return p;
   endfunction

   // Anything outside 0..9 (including BLANK_CODE) lights no segment.
   function automatic logic [7:0] seg_decode(input logic [3:0] code);
      logic [7:0] seg;
      seg = 8'hFF;
      if (code < 4'd10) begin
         seg = SEG_PAT[code];
      end
      return seg;
   endfunction

endpackage

// File: rtl/score_display_n_bin2bcd.sv
// Sequential double-dabble converter with a one-deep pending request and
// overflow saturation; digits_o changes only on the commit edge.
module bin2bcd_seq
   import score_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [BIN_W-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  overflow_o,
   output logic [4*DIGITS-1:0]   digits_o
);

   // One spare nibble so the scratch never overflows for legal BIN_W.
   localparam int unsigned BCD_W = 4 * (DIGITS + 1);
   localparam int unsigned SR_W  = BCD_W + BIN_W;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam logic [31:0] LIMIT = pow10(DIGITS);

   conv_state_e          state_q, state_d;
   logic [SR_W-1:0]      sr_q, sr_d, sr_adj;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 pend_q, pend_d;
   logic [BIN_W-1:0]     pend_val_q, pend_val_d;
   logic                 ovf_cand_q, ovf_cand_d;
   logic                 ovf_q, ovf_d;
   logic                 done_q, done_d;
   logic [4*DIGITS-1:0]  digits_q, digits_d;
   logic                 load;
   logic [BIN_W-1:0]     load_val;

   // Converter state, scratch, pending request and committed result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CONV_IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         ovf_cand_q <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         digits_q   <= '0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         ovf_cand_q <= ovf_cand_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         digits_q   <= digits_d;
      end
   end

   // Next-state: add-3/shift steps, commit, and chained reload from pending.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      ovf_cand_d = ovf_cand_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      digits_d   = digits_q;
      load       = 1'b0;
      load_val   = '0;
      sr_adj     = sr_q;
      for (int unsigned k = 0; k < DIGITS + 1; k++) begin
         if (sr_q[BIN_W+4*k +: 4] >= 4'd5) begin
            sr_adj[BIN_W+4*k +: 4] = sr_q[BIN_W+4*k +: 4] + 4'd3;
         end
      end
      unique case (state_q)
         CONV_IDLE: begin
            if (start_i) begin
               load     = 1'b1;
               load_val = bin_i;
            end
         end
         CONV_SHIFT: begin
            sr_d  = {sr_adj[SR_W-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
            if (start_i) begin
               pend_d     = 1'b1;
               pend_val_d = bin_i;
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d = CONV_COMMIT;
            end
         end
         CONV_COMMIT: begin
            done_d   = 1'b1;
            ovf_d    = ovf_cand_q;
            digits_d = ovf_cand_q ? {DIGITS{4'h9}} : sr_q[BIN_W +: 4*DIGITS];
            // A start arriving now is newer than any pending one, so it wins.
            if (start_i || pend_q) begin
               load     = 1'b1;
               load_val = start_i ? bin_i : pend_val_q;
               pend_d   = 1'b0;
            end else begin
               state_d = CONV_IDLE;
            end
         end
         default: state_d = CONV_IDLE;
      endcase
      if (load) begin
         sr_d       = {{BCD_W{1'b0}}, load_val};
         cnt_d      = CNT_W'(BIN_W);
         ovf_cand_d = (32'(load_val) >= LIMIT);
         state_d    = CONV_SHIFT;
      end
   end

   assign busy_o     = (state_q != CONV_IDLE);
   assign done_o     = done_q;
   assign overflow_o = ovf_q;
   assign digits_o   = digits_q;

endmodule

// File: rtl/score_display_n.sv
// N-digit score display: BCD conversion, multiplexed seven-segment drive and
// glyph-ROM overlay. Build option SCORE_LEADING_ZERO_BLANK_EN blanks leading
// zero digits on both the seven-segment display and the overlay.
module score_display_n
   import score_pkg::*;
#(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned BIN_W      = 14,
   parameter int unsigned X0         = 336,
   parameter int unsigned Y0         = 16,
   parameter int unsigned SCALE_LOG2 = 0,
   parameter int unsigned MUX_BITS   = 17
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [BIN_W-1:0]   score,
   output logic               busy,
   output logic               done,
   output logic               overflow,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   output logic [11:0]        rom_addr,
   input  logic               rom_data,
   output logic               score_on,
   output logic [7:0]         sseg,
   output logic [DIGITS-1:0]  an
);

   localparam int unsigned CELL  = GLYPH_W << SCALE_LOG2;
   localparam int unsigned SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [4*DIGITS-1:0]  digits;
   logic [DIGITS-1:0]    blank;
   logic [MUX_BITS-1:0]  mux_q, mux_d;
   logic [SEL_W-1:0]     sel;
   logic [3:0]           code;
   logic [7:0]           sseg_q, sseg_d;
   logic [DIGITS-1:0]    an_q, an_d;
   logic                 hit, hit_blank;
   logic                 in_cell_q, in_cell_d;
   logic [11:0]          addr;
   logic [31:0]          xu, yu, lo;

   bin2bcd_seq #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) u_conv (
      .clk        (clk),
      .rst        (reset),
      .start_i    (start),
      .bin_i      (score),
      .busy_o     (busy),
      .done_o     (done),
      .overflow_o (overflow),
      .digits_o   (digits)
   );

`ifdef SCORE_LEADING_ZERO_BLANK_EN
   logic lead;
   // A digit is blank when it and every more significant digit are zero.
   always_comb begin
      blank = '0;
      lead  = 1'b1;
      for (int unsigned j = DIGITS - 1; j > 0; j--) begin
         lead     = lead & (digits[4*j +: 4] == 4'd0);
         blank[j] = lead;
      end
   end
`else
   assign blank = '0;
`endif

   // Digit select from the refresh counter top bits, folded into range.
   always_comb begin
      mux_d  = mux_q + MUX_BITS'(1);
      sel    = SEL_W'(32'(mux_q[MUX_BITS-1 -: SEL_W]) % DIGITS);
      code   = blank[sel] ? BLANK_CODE : digits[4*sel +: 4];
      sseg_d = seg_decode(code);
      an_d   = ~(DIGITS'(1) << sel);
   end

   // Pixel to glyph ROM address; digit 0 of the overlay is the leftmost.
   always_comb begin
      xu        = 32'(x);
      yu        = 32'(y);
      lo        = '0;
      hit       = 1'b0;
      hit_blank = 1'b0;
      addr      = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         lo = X0 + i * CELL;
         if (xu >= lo && xu < lo + CELL && yu >= Y0 && yu < Y0 + CELL) begin
            hit       = 1'b1;
            hit_blank = blank[DIGITS-1-i];
            addr      = {digits[4*(DIGITS-1-i) +: 4],
                         4'((yu - Y0) >> SCALE_LOG2),
                         4'((xu - lo) >> SCALE_LOG2)};
         end
      end
      in_cell_d = hit & ~hit_blank;
   end

   // Refresh counter, segment/anode pair and in-cell flag aligned to ROM data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mux_q     <= '0;
         sseg_q    <= SEG_PAT[0];
         an_q      <= ~DIGITS'(1);
         in_cell_q <= 1'b0;
      end else begin
         mux_q     <= mux_d;
         sseg_q    <= sseg_d;
         an_q      <= an_d;
         in_cell_q <= in_cell_d;
      end
   end

   assign sseg     = sseg_q;
   assign an       = an_q;
   assign rom_addr = addr;
   assign score_on = in_cell_q & rom_data;

endmodule

// File: tb/tb_score_display_n.sv
`timescale 1ns/1ps
module tb_score_display_n;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [13:0] score;
   logic        busy, done, overflow;
   logic [9:0]  x, y;
   logic [11:0] rom_addr;
   logic        rom_data;
   logic        score_on;
   logic [7:0]  sseg;
   logic [3:0]  an;

   logic        busy2, done2, overflow2;
   logic [9:0]  x2, y2;
   logic [11:0] rom_addr2;
   logic        rom_data2;
   logic        score_on2;
   logic [7:0]  sseg2;
   logic [3:0]  an2;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] TB_SEG [10] = '{
      8'b10000001, 8'b11001111, 8'b10010010, 8'b10000110, 8'b11001100,
      8'b10100100, 8'b10100000, 8'b10001111, 8'b10000000, 8'b10000100
   };

   typedef struct {
      logic [13:0] score;
      logic [15:0] digits;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] addr;
      logic        hit;
   } ovl_t;

   score_display_n #(
      .DIGITS(4), .BIN_W(14), .X0(336), .Y0(16), .SCALE_LOG2(0), .MUX_BITS(6)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .score(score),
      .busy(busy), .done(done), .overflow(overflow),
      .x(x), .y(y), .rom_addr(rom_addr), .rom_data(rom_data),
      .score_on(score_on), .sseg(sseg), .an(an)
   );

   score_display_n #(
      .DIGITS(4), .BIN_W(14), .X0(336), .Y0(16), .SCALE_LOG2(1), .MUX_BITS(6)
   ) dut2 (
      .clk(clk), .reset(reset), .start(start), .score(score),
      .busy(busy2), .done(done2), .overflow(overflow2),
      .x(x2), .y(y2), .rom_addr(rom_addr2), .rom_data(rom_data2),
      .score_on(score_on2), .sseg(sseg2), .an(an2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic exp_blank(input logic [15:0] d, input int unsigned p);
      logic b;
      b = 1'b0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      if (p > 0) begin
         b = 1'b1;
         for (int unsigned q = p; q < 4; q++) begin
            if (d[4*q +: 4] != 4'd0) b = 1'b0;
         end
      end
`endif
      return b;
   endfunction

   function automatic logic [7:0] exp_seg(input logic [15:0] d, input int unsigned p);
      logic [3:0] n;
      n = d[4*p +: 4];
      return exp_blank(d, p) ? 8'hFF : TB_SEG[n];
   endfunction

   // Reads committed digits through the overlay address (row = 16*digit at y=Y0).
   task automatic read_digits(output logic [15:0] d);
      d = '0;
      for (int i = 0; i < 4; i++) begin
         x = 10'(336 + 16 * i);
         y = 10'd16;
         #1;
         d[4*(3-i) +: 4] = rom_addr[11:8];
      end
   endtask

   task automatic convert(input logic [13:0] v, output int ncyc);
      score = v;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ncyc  = 0;
      while (busy && ncyc < 100) begin
         ncyc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic scan_sseg(input logic [15:0] d, input string tag);
      logic [3:0] seen;
      int p;
      seen = '0;
      for (int c = 0; c < 64; c++) begin
         @(posedge clk); #1;
         p = -1;
         for (int k = 0; k < 4; k++) if (an == ~(4'b0001 << k)) p = k;
         if (p < 0) begin
            chk({tag, "_an_onehot"}, 32'(an), 32'hE);
         end else begin
            seen[p] = 1'b1;
            chk({tag, "_sseg"}, {an, 16'h0, sseg}, {an, 16'h0, exp_seg(d, p)});
         end
      end
      chk({tag, "_all_digits_scanned"}, 32'(seen), 32'hF);
   endtask

   vec_t        vecs [9];
   ovl_t        ovls [8];
   int          ncyc;
   logic [15:0] dg, d1, d2;
   int          dc, fd, sd, first_idle, bad;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{14'd0,     16'h0000, 1'b0};
      vecs[1] = '{14'd1234,  16'h1234, 1'b0};
      vecs[2] = '{14'd9999,  16'h9999, 1'b0};
      vecs[3] = '{14'd10000, 16'h9999, 1'b1};
      vecs[4] = '{14'd42,    16'h0042, 1'b0};
      vecs[5] = '{14'd16383, 16'h9999, 1'b1};
      vecs[6] = '{14'd7,     16'h0007, 1'b0};
      vecs[7] = '{14'd905,   16'h0905, 1'b0};
      vecs[8] = '{14'd10,    16'h0010, 1'b0};

      ovls[0] = '{10'd336, 10'd16, 12'h100, 1'b1};
      ovls[1] = '{10'd352, 10'd16, 12'h200, 1'b1};
      ovls[2] = '{10'd335, 10'd16, 12'h000, 1'b0};
      ovls[3] = '{10'd399, 10'd31, 12'h4FF, 1'b1};
      ovls[4] = '{10'd400, 10'd31, 12'h000, 1'b0};
      ovls[5] = '{10'd370, 10'd20, 12'h342, 1'b1};
      ovls[6] = '{10'd340, 10'd32, 12'h000, 1'b0};
      ovls[7] = '{10'd340, 10'd15, 12'h000, 1'b0};

      reset = 1'b1; start = 1'b0; score = '0;
      x = '0; y = '0; rom_data = 1'b1;
      x2 = '0; y2 = '0; rom_data2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_sseg", 32'(sseg), 32'h81);
      chk("reset_an", 32'(an), 32'hE);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_overflow", 32'(overflow), 32'h0);
      chk("reset_score_on", 32'(score_on), 32'h0);
      read_digits(dg);
      chk("reset_digits", 32'(dg), 32'h0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // Table-driven conversions.
      for (int v = 0; v < 9; v++) begin
         convert(vecs[v].score, ncyc);
         chk("busy_cycles", ncyc, 15);
         chk("done_pulse", 32'(done), 32'h1);
         chk("overflow", 32'(overflow), 32'(vecs[v].ovf));
         read_digits(dg);
         chk("digits", 32'(dg), 32'(vecs[v].digits));
         @(posedge clk); #1;
         chk("done_one_cycle", 32'(done), 32'h0);
         scan_sseg(vecs[v].digits, "scan");
      end

      // Reset mid-conversion with a pending request outstanding.
      convert(14'd10000, ncyc);
      chk("pre_reset_overflow", 32'(overflow), 32'h1);
      score = 14'd1234; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1; score = 14'd99; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1; #2 reset = 1'b1; #1;
      chk("midreset_busy", 32'(busy), 32'h0);
      chk("midreset_overflow", 32'(overflow), 32'h0);
      chk("midreset_sseg", 32'(sseg), 32'h81);
      chk("midreset_an", 32'(an), 32'hE);
      read_digits(dg);
      chk("midreset_digits", 32'(dg), 32'h0);
      @(negedge clk) reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (busy || done) bad++;
      end
      chk("pending_cleared_by_reset", bad, 0);

      // Starts while busy: the newest pending score runs next with no idle gap.
      score = 14'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      dc = 0; fd = -1; sd = -1; first_idle = -1; d1 = '0; d2 = '0;
      for (int n = 0; n < 60; n++) begin
         if (done) begin
            dc++;
            if (dc == 1) begin fd = n; read_digits(d1); end
            else if (dc == 2) begin sd = n; read_digits(d2); end
         end
         if (!busy && first_idle < 0) first_idle = n;
         if (n == 2) begin score = 14'd7; start = 1'b1; end
         if (n == 3) start = 1'b0;
         if (n == 4) begin score = 14'd8; start = 1'b1; end
         if (n == 5) start = 1'b0;
         @(posedge clk); #1;
      end
      chk("pend_first_done_at", fd, 15);
      chk("pend_second_done_at", sd, 30);
      chk("pend_done_count", dc, 2);
      chk("pend_busy_until", first_idle, 30);
      chk("pend_first_digits", 32'(d1), 32'h0005);
      chk("pend_second_digits", 32'(d2), 32'h0008);

      // Overlay address table and 1-cycle score_on latency.
      convert(14'd1234, ncyc);
      rom_data = 1'b1;
      for (int v = 0; v < 8; v++) begin
         x = ovls[v].x; y = ovls[v].y;
         #1;
         chk("ovl_rom_addr", 32'(rom_addr), 32'(ovls[v].addr));
         @(posedge clk); #1;
         chk("ovl_score_on", 32'(score_on), 32'(ovls[v].hit));
      end
      x = 10'd0; y = 10'd16;
      @(posedge clk); #1;
      x = 10'd352; #1;
      chk("ovl_latency_before_edge", 32'(score_on), 32'h0);
      @(posedge clk); #1;
      chk("ovl_latency_after_edge", 32'(score_on), 32'h1);
      rom_data = 1'b0; #1;
      chk("ovl_follows_rom_data", 32'(score_on), 32'h0);
      rom_data = 1'b1;

      // Scaled overlay instance (cell size 32).
      x2 = 10'd369; y2 = 10'd21; rom_data2 = 1'b1; #1;
      chk("scale_rom_addr", 32'(rom_addr2), 32'h220);
      @(posedge clk); #1;
      chk("scale_score_on", 32'(score_on2), 32'h1);
      rom_data2 = 1'b0; #1;
      chk("scale_score_on_rom0", 32'(score_on2), 32'h0);
      x2 = 10'd399; y2 = 10'd47; #1;
      chk("scale_rom_addr_corner", 32'(rom_addr2), 32'h2FF);
      x2 = 10'd464; rom_data2 = 1'b1; #1;
      chk("scale_rom_addr_outside", 32'(rom_addr2), 32'h0);
      @(posedge clk); #1;
      chk("scale_score_on_outside", 32'(score_on2), 32'h0);

      // Leading-zero handling in the overlay cells.
      convert(14'd7, ncyc);
      for (int i = 0; i < 4; i++) begin
         x = 10'(336 + 16 * i + 3); y = 10'd20;
         @(posedge clk); #1;
         chk("lz_cell_score_on", 32'(score_on), 32'(!exp_blank(16'h0007, 3 - i)));
      end
      convert(14'd0, ncyc);
      scan_sseg(16'h0000, "zero_scan");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
